// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the 4-way bus arbiter: requester count, index width,
// FSM state encoding and a small index-to-one-hot helper.
package bus_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr,
// wrapping modulo 4.
module rr_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back toward ptr so the nearest one wins.
    always_comb begin
        valid = |req;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin bus arbiter with a per-tenure hold limit and a
// single turnaround cycle between tenures. sel feeds the shared mux4 directly.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD  = 16,
    parameter int RESET_PTR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic               busy,
    output logic               hold_expired
);

    // state | meaning
    // IDLE  | no owner; arbitrate when any req is high
    // GRANT | owner in sel holds the bus; watch its req and the hold limit
    // TURN  | one dead cycle after a release; arbitrates like IDLE

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  RST_IDX   = IDX_W'(RESET_PTR);

    arb_state_t         state, state_next;
    logic [IDX_W-1:0]   ptr, ptr_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_next;
    logic               armed, armed_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [IDX_W-1:0]   sel_next;
    logic               busy_next;
    logic               hold_expired_next;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // armed stays low for the first edge after reset so no grant lands there.
    always_comb begin
        state_next        = state;
        ptr_next          = ptr;
        hold_cnt_next     = hold_cnt;
        armed_next        = 1'b1;
        gnt_next          = gnt;
        sel_next          = sel;
        busy_next         = busy;
        hold_expired_next = 1'b0;

        case (state)
            ST_IDLE, ST_TURN: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
                busy_next  = 1'b0;
                if (armed && pick_valid) begin
                    state_next    = ST_GRANT;
                    gnt_next      = idx_to_onehot(pick_idx);
                    sel_next      = pick_idx;
                    busy_next     = 1'b1;
                    hold_cnt_next = '0;
                end
            end
            ST_GRANT: begin
                if (!req[sel]) begin
                    state_next = ST_TURN;
                    gnt_next   = '0;
                    busy_next  = 1'b0;
                    ptr_next   = sel + IDX_W'(1);
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                    state_next        = ST_TURN;
                    gnt_next          = '0;
                    busy_next         = 1'b0;
                    ptr_next          = sel + IDX_W'(1);
                    hold_expired_next = 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= RST_IDX;
            hold_cnt     <= '0;
            armed        <= 1'b0;
            gnt          <= '0;
            sel          <= RST_IDX;
            busy         <= 1'b0;
            hold_expired <= 1'b0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            hold_cnt     <= hold_cnt_next;
            armed        <= armed_next;
            gnt          <= gnt_next;
            sel          <= sel_next;
            busy         <= busy_next;
            hold_expired <= hold_expired_next;
        end
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench: three arbiter configurations share one stimulus stream and
// are compared every cycle against a tenure-level reference model.
module tb_bus_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt_w  [3];
    logic [1:0] sel_w  [3];
    logic       busy_w [3];
    logic       exp_w  [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance configuration: default, MAX_HOLD=4, MAX_HOLD=3 with RESET_PTR=2.
    int mh [3] = '{16, 4, 3};
    int rp [3] = '{0, 0, 2};

    // Reference model: owner index (-1 when nobody owns the bus) and cycles held.
    int m_owner [3];
    int m_ptr   [3];
    int m_sel   [3];
    int m_held  [3];
    int m_armed [3];
    int m_exp   [3];

    logic [3:0] prev_g   [3];
    int         wait_cnt [3][4];
    logic [3:0] req_edge;
    logic       rst_edge;

    bus_arbiter4 #(.MAX_HOLD(16), .RESET_PTR(0)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[0]), .sel(sel_w[0]), .busy(busy_w[0]), .hold_expired(exp_w[0])
    );
    bus_arbiter4 #(.MAX_HOLD(4), .RESET_PTR(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[1]), .sel(sel_w[1]), .busy(busy_w[1]), .hold_expired(exp_w[1])
    );
    bus_arbiter4 #(.MAX_HOLD(3), .RESET_PTR(2)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_w[2]), .sel(sel_w[2]), .busy(busy_w[2]), .hold_expired(exp_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic release_bus(input int d);
        m_ptr[d]   = (m_owner[d] + 1) % 4;
        m_owner[d] = -1;
    endtask

    task automatic model_step(input int d, input logic rst, input logic [3:0] r);
        bit found;
        m_exp[d] = 0;
        if (!rst) begin
            m_owner[d] = -1;
            m_ptr[d]   = rp[d];
            m_sel[d]   = rp[d];
            m_held[d]  = 0;
            m_armed[d] = 0;
        end else if (m_owner[d] >= 0) begin
            if (!r[m_owner[d]]) begin
                release_bus(d);
            end else if (mh[d] != 0 && m_held[d] == mh[d]) begin
                release_bus(d);
                m_exp[d] = 1;
            end else begin
                m_held[d]++;
            end
        end else if (m_armed[d] == 0) begin
            m_armed[d] = 1;
        end else if (r != 4'b0000) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr[d] + k) % 4;
                if (!found && r[i]) begin
                    found      = 1;
                    m_owner[d] = i;
                    m_sel[d]   = i;
                    m_held[d]  = 1;
                end
            end
        end
    endtask

    task automatic observe(input int d);
        logic [3:0] g;
        logic [3:0] eg;
        g  = gnt_w[d];
        eg = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0000;
        check($sformatf("gnt%0d", d), 32'(g), 32'(eg));
        check($sformatf("sel%0d", d), 32'(sel_w[d]), 32'(m_sel[d]));
        check($sformatf("busy%0d", d), 32'(busy_w[d]), 32'(m_owner[d] >= 0));
        check($sformatf("hold_expired%0d", d), 32'(exp_w[d]), 32'(m_exp[d]));
        check($sformatf("onehot%0d", d), 32'($onehot0(g)), 32'd1);
        if (!rst_edge) begin
            for (int i = 0; i < 4; i++) wait_cnt[d][i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) if (!req_edge[i]) wait_cnt[d][i] = 0;
            if (g != 4'b0000 && g != prev_g[d]) begin
                check($sformatf("gnt_req%0d", d), 32'(g & req_edge), 32'(g));
                for (int i = 0; i < 4; i++) begin
                    if (g[i]) begin
                        wait_cnt[d][i] = 0;
                    end else if (req_edge[i]) begin
                        wait_cnt[d][i]++;
                        check($sformatf("rr_wait%0d_%0d", d, i), 32'(wait_cnt[d][i] <= 3), 32'd1);
                    end
                end
            end
        end
        prev_g[d] = g;
    endtask

    task automatic cycle();
        @(posedge clk);
        req_edge = req;
        rst_edge = rst_n;
        for (int d = 0; d < 3; d++) model_step(d, rst_edge, req_edge);
        @(negedge clk);
        for (int d = 0; d < 3; d++) observe(d);
    endtask

    task automatic reset_and_arm(input logic [3:0] r_during);
        rst_n = 1'b0;
        req   = r_during;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        int pulses;
        int gcnt;
        int order[$];
        logic [3:0] pg;

        rst_n = 1'b0;
        req   = 4'b0000;
        for (int d = 0; d < 3; d++) begin
            m_owner[d] = -1; m_ptr[d] = rp[d]; m_sel[d] = rp[d];
            m_held[d] = 0; m_armed[d] = 0; m_exp[d] = 0; prev_g[d] = 4'b0000;
            for (int i = 0; i < 4; i++) wait_cnt[d][i] = 0;
        end
        @(negedge clk);

        // Single requester held 5 cycles; request already high at the release edge.
        rst_n = 1'b0;
        req   = 4'b0100;
        cycle();
        cycle();
        check("rst_gnt", 32'(gnt_w[0]), 32'd0);
        check("rst_sel_ptr2", 32'(sel_w[2]), 32'd2);
        rst_n = 1'b1;
        cycle();
        check("no_grant_at_release", 32'(gnt_w[0]), 32'd0);
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("single_hold", 32'(gnt_w[0]), 32'h4);
            check("single_sel", 32'(sel_w[0]), 32'd2);
        end
        req = 4'b0000;
        cycle();
        check("single_turn", 32'(gnt_w[0]), 32'd0);
        check("single_turn_sel", 32'(sel_w[0]), 32'd2);
        cycle();
        check("single_idle", 32'(busy_w[0]), 32'd0);

        // All four requesting with MAX_HOLD=4: order 0,1,2,3,0 with expiry pulses.
        reset_and_arm(4'b0000);
        req    = 4'b1111;
        pulses = 0;
        order.delete();
        for (int n = 0; n < 25; n++) begin
            pg = gnt_w[1];
            cycle();
            if (exp_w[1]) pulses++;
            if (gnt_w[1] != 4'b0000 && pg == 4'b0000) order.push_back(int'(sel_w[1]));
        end
        check("rr4_pulses", 32'(pulses), 32'd5);
        check("rr4_tenures", 32'(order.size()), 32'd5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            check($sformatf("rr4_order%0d", k), 32'(order[k]), 32'(k % 4));

        // Owner 1 drops while 0 and 3 wait: pointer 2 must pick 3, not 0.
        reset_and_arm(4'b0000);
        req = 4'b0010;
        cycle();
        check("skip_owner1", 32'(gnt_w[0]), 32'h2);
        req = 4'b1011;
        cycle();
        req = 4'b1001;
        cycle();
        check("skip_turn", 32'(gnt_w[0]), 32'd0);
        cycle();
        check("skip_to3", 32'(gnt_w[0]), 32'h8);

        // Lone requester 2 with MAX_HOLD=3: 3 on, 1 off, repeating.
        reset_and_arm(4'b0000);
        req    = 4'b0100;
        pulses = 0;
        gcnt   = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (exp_w[2]) pulses++;
            if (gnt_w[2] == 4'b0100) gcnt++;
        end
        check("lone_gnt_cycles", 32'(gcnt), 32'd9);
        check("lone_pulses", 32'(pulses), 32'd3);

        // Reset during a grant to requester 3.
        reset_and_arm(4'b0000);
        req = 4'b1000;
        cycle();
        cycle();
        check("rst_mid_pre", 32'(gnt_w[0]), 32'h8);
        rst_n = 1'b0;
        cycle();
        check("rst_mid_gnt", 32'(gnt_w[0]), 32'd0);
        check("rst_mid_sel", 32'(sel_w[2]), 32'd2);
        check("rst_mid_exp", 32'(exp_w[1]), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("rst_mid_release", 32'(gnt_w[0]), 32'd0);
        cycle();
        check("rst_mid_regrant", 32'(gnt_w[0]), 32'h8);

        // Random traffic: requesters raise at will and hold until served awhile.
        for (int n = 0; n < 10000; n++) begin
            logic [3:0] r;
            r = req;
            for (int i = 0; i < 4; i++) begin
                if (!r[i]) begin
                    if ($urandom_range(99, 0) < 25) r[i] = 1'b1;
                end else if (gnt_w[0][i] && $urandom_range(99, 0) < 30) begin
                    r[i] = 1'b0;
                end
            end
            req   = r;
            rst_n = ($urandom_range(999, 0) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
